dc_sweep_sequencer: RTL and testbench

//  Sequences a DC operating-point sweep on a source/load/DUT test circuit.

---
 rtl/dc_sweep_if.sv | 37 +++
 rtl/dc_sweep_sequencer.sv | 132 +++++++++++++
 tb/tb_dc_sweep_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_sweep_if.sv
// Measurement request/ack link and result valid/ready stream between the
// sweep sequencer (master) and the ADC front end / result consumer (slave).
interface dc_sweep_if #(
    parameter int CODE_W = 12,
    parameter int DATA_W = 16
);
    logic              meas_req;
    logic              meas_ack;
    logic [DATA_W-1:0] meas_data;
    logic              res_valid;
    logic              res_ready;
    logic [CODE_W-1:0] res_code;
    logic [DATA_W-1:0] res_data;
    logic              res_last;

    modport master (
        output meas_req,
        input  meas_ack,
        input  meas_data,
        output res_valid,
        input  res_ready,
        output res_code,
        output res_data,
        output res_last
    );

    modport slave (
        input  meas_req,
        output meas_ack,
        output meas_data,
        input  res_valid,
        output res_ready,
        input  res_code,
        input  res_data,
        input  res_last
    );
endinterface

// File: rtl/dc_sweep_sequencer.sv
// DC operating-point sweep sequencer: steps a source code, waits a settle time,
// requests one measurement per point and streams (code, measurement) results.
module dc_sweep_sequencer #(
    parameter int CODE_W   = 12,
    parameter int DATA_W   = 16,
    parameter int PTS_W    = 10,
    parameter int SETTLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_W-1:0]   cfg_start,
    input  logic [CODE_W-1:0]   cfg_step,
    input  logic [PTS_W-1:0]    cfg_npts,
    input  logic [SETTLE_W-1:0] cfg_settle,
    output logic [CODE_W-1:0]   src_code,
    output logic                src_en,
    output logic                busy,
    output logic                done,
    output logic                err_ovf,
    dc_sweep_if.master          link
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SET    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_MEAS   = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    logic [2:0]          state_reg, state_next;
    logic [CODE_W-1:0]   code_reg;
    logic [CODE_W-1:0]   step_reg;
    logic [PTS_W-1:0]    npts_reg;
    logic [PTS_W-1:0]    idx_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [CODE_W-1:0]   res_code_reg;
    logic [DATA_W-1:0]   res_data_reg;
    logic                res_last_reg;
    logic                err_ovf_reg;

    logic [CODE_W:0] code_sum;
    logic            last_point;
    logic            accept_start;
    logic            capture;
    logic            handshake;
    logic            advance;
    logic            overflow;

    // Extra carry bit detects a step past full scale; the code never wraps.
    assign code_sum     = {1'b0, code_reg} + {1'b0, step_reg};
    assign last_point   = (idx_reg == npts_reg - PTS_W'(1));
    assign accept_start = (state_reg == ST_IDLE) && start;
    assign capture      = (state_reg == ST_MEAS) && link.meas_ack && !abort;
    assign handshake    = (state_reg == ST_OUT) && link.res_ready && !abort;
    assign advance      = handshake && !res_last_reg && !code_sum[CODE_W];
    assign overflow     = handshake && !res_last_reg && code_sum[CODE_W];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = (cfg_npts == '0) ? ST_FIN : ST_SET;
            ST_SET:    state_next = (settle_reg == '0) ? ST_MEAS : ST_SETTLE;
            ST_SETTLE: if (settle_cnt_reg == '0) state_next = ST_MEAS;
            ST_MEAS:   if (link.meas_ack) state_next = ST_OUT;
            ST_OUT:    if (link.res_ready) state_next = (advance) ? ST_SET : ST_FIN;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Abort overrides everything; FIN is already the terminating state.
        if (abort && (state_reg != ST_IDLE) && (state_reg != ST_FIN))
            state_next = ST_FIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            code_reg       <= '0;
            step_reg       <= '0;
            npts_reg       <= '0;
            idx_reg        <= '0;
            settle_reg     <= '0;
            settle_cnt_reg <= '0;
            res_code_reg   <= '0;
            res_data_reg   <= '0;
            res_last_reg   <= 1'b0;
            err_ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_start) begin
                code_reg    <= cfg_start;
                step_reg    <= cfg_step;
                npts_reg    <= cfg_npts;
                settle_reg  <= cfg_settle;
                idx_reg     <= '0;
                err_ovf_reg <= 1'b0;
            end
            // Loaded with settle-1 so SETTLE lasts exactly cfg_settle cycles.
            if (state_reg == ST_SET)
                settle_cnt_reg <= settle_reg - SETTLE_W'(1);
            else if (state_reg == ST_SETTLE)
                settle_cnt_reg <= settle_cnt_reg - SETTLE_W'(1);
            if (capture) begin
                res_code_reg <= code_reg;
                res_data_reg <= link.meas_data;
                res_last_reg <= last_point;
            end
            if (advance) begin
                code_reg <= code_sum[CODE_W-1:0];
                idx_reg  <= idx_reg + PTS_W'(1);
            end
            if (overflow)
                err_ovf_reg <= 1'b1;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_FIN);
    assign src_en   = busy && !done;
    assign src_code = src_en ? code_reg : '0;
    assign err_ovf  = err_ovf_reg;

    // Request and valid drop in the abort cycle itself, not one cycle later.
    assign link.meas_req  = (state_reg == ST_MEAS) && !abort;
    assign link.res_valid = (state_reg == ST_OUT) && !abort;
    assign link.res_code  = res_code_reg;
    assign link.res_data  = res_data_reg;
    assign link.res_last  = res_last_reg;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Randomized bench for dc_sweep_sequencer: expected sweep points are computed
// from start/step/npts arithmetic and compared against the streamed results.
`timescale 1ns/1ps
module tb_dc_sweep_sequencer;

    localparam int CODE_W   = 12;
    localparam int DATA_W   = 16;
    localparam int PTS_W    = 10;
    localparam int SETTLE_W = 16;
    localparam int CODE_MAX = (1 << CODE_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [CODE_W-1:0]   cfg_start = '0;
    logic [CODE_W-1:0]   cfg_step = '0;
    logic [PTS_W-1:0]    cfg_npts = '0;
    logic [SETTLE_W-1:0] cfg_settle = '0;
    logic [CODE_W-1:0]   src_code;
    logic                src_en;
    logic                busy;
    logic                done;
    logic                err_ovf;

    dc_sweep_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) link ();

    dc_sweep_sequencer #(
        .CODE_W(CODE_W), .DATA_W(DATA_W), .PTS_W(PTS_W), .SETTLE_W(SETTLE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_npts(cfg_npts),
        .cfg_settle(cfg_settle), .src_code(src_code), .src_en(src_en),
        .busy(busy), .done(done), .err_ovf(err_ovf), .link(link)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int err_cnt   = 0;
    int sweep_no  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL sweep %0d %s: got 0x%0h expected 0x%0h", sweep_no, tag, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_eq({tag, "_src_code"}, 32'(src_code), 0);
        chk_eq({tag, "_src_en"}, 32'(src_en), 0);
        chk_eq({tag, "_busy"}, 32'(busy), 0);
        chk_eq({tag, "_done"}, 32'(done), 0);
        chk_eq({tag, "_err_ovf"}, 32'(err_ovf), 0);
        chk_eq({tag, "_meas_req"}, 32'(link.meas_req), 0);
        chk_eq({tag, "_res_valid"}, 32'(link.res_valid), 0);
    endtask

    // ack_dly < 0 picks a random ack delay per point.
    // ready_mode: 0 always ready, 1 random, 2 hold ready low 10 cycles on point 2.
    // abort_sel:  0 none, 1 abort at cycle 3, 2 abort on first res_valid.
    task automatic run_sweep(input int s_start, input int s_step, input int s_npts,
                             input int s_settle, input int ack_dly,
                             input int ready_mode, input int abort_sel);
        int exp_code [64];
        logic [DATA_W-1:0] exp_data [64];
        int  n_exp, n_got, n_meas, c, ack_wait, low_cnt, first_req;
        bit  err_exp, fin, aborted, en_seen, req_seen, valid_seen, timed_out, abort_now;
        logic s_req, s_valid;

        sweep_no++;
        n_exp = 0;
        for (int k = 0; k < s_npts; k++) begin
            if (s_start + k * s_step > CODE_MAX) break;
            exp_code[k] = s_start + k * s_step;
            n_exp++;
        end
        err_exp = (n_exp < s_npts);
        n_got = 0; n_meas = 0; ack_wait = -1; low_cnt = 0; first_req = -1;
        fin = 0; aborted = 0; en_seen = 0; req_seen = 0; valid_seen = 0; timed_out = 0;

        @(negedge clk);
        cfg_start  = CODE_W'(s_start);
        cfg_step   = CODE_W'(s_step);
        cfg_npts   = PTS_W'(s_npts);
        cfg_settle = SETTLE_W'(s_settle);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_start  = CODE_W'($urandom);
        cfg_step   = CODE_W'($urandom);
        cfg_npts   = PTS_W'($urandom);
        cfg_settle = SETTLE_W'($urandom);
        c = 1;

        while (!fin) begin
            s_req   = link.meas_req;
            s_valid = link.res_valid;
            if (abort) begin
                abort = 1'b0;
                chk_eq("abort_to_fin", 32'(done), 1);
            end
            if (c == 1) chk_eq("err_ovf_clear", 32'(err_ovf), 0);
            if (src_en) en_seen = 1;
            if (s_req) req_seen = 1;
            if (s_valid) valid_seen = 1;

            if (done) begin
                chk_eq("fin_src_en", 32'(src_en), 0);
                chk_eq("fin_src_code", 32'(src_code), 0);
                chk_eq("fin_busy", 32'(busy), 1);
                if (!aborted) begin
                    chk_eq("result_count", n_got, n_exp);
                    chk_eq("err_ovf", 32'(err_ovf), 32'(err_exp));
                end
                if (s_npts == 0) begin
                    chk_eq("empty_done_cycle", c, 1);
                    chk_eq("empty_src_en", 32'(en_seen), 0);
                    chk_eq("empty_meas_req", 32'(req_seen), 0);
                    chk_eq("empty_res_valid", 32'(valid_seen), 0);
                end
                fin = 1;
            end else begin
                if (s_req) begin
                    if (first_req < 0) begin
                        first_req = c;
                        chk_eq("first_req_cycle", c, 2 + s_settle);
                    end
                    chk_eq("meas_src_en", 32'(src_en), 1);
                    if (n_meas < 64) chk_eq("meas_src_code", 32'(src_code), exp_code[n_meas]);
                end

                abort_now = !aborted && ((abort_sel == 1 && c == 3) || (abort_sel == 2 && s_valid));

                if (abort_now) link.res_ready = 1'b0;
                else if (ready_mode == 0) link.res_ready = 1'b1;
                else if (ready_mode == 1) link.res_ready = 1'($urandom_range(0, 1));
                else if (s_valid && n_got == 1 && low_cnt < 10) begin
                    link.res_ready = 1'b0;
                    low_cnt++;
                end else link.res_ready = 1'b1;

                if (s_valid && n_got < 64) begin
                    chk_eq("no_req_while_valid", 32'(s_req), 0);
                    chk_eq("res_code", 32'(link.res_code), exp_code[n_got]);
                    chk_eq("res_data", 32'(link.res_data), 32'(exp_data[n_got]));
                    chk_eq("res_last", 32'(link.res_last), 32'(n_got == s_npts - 1));
                    if (link.res_ready) n_got++;
                end

                // ADC model: ack after a short delay, one cycle wide, fresh data.
                if (link.meas_ack) link.meas_ack = 1'b0;
                else if (s_req && !abort_now) begin
                    if (ack_wait < 0) ack_wait = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
                    if (ack_wait == 0) begin
                        link.meas_ack  = 1'b1;
                        link.meas_data = DATA_W'($urandom);
                        if (n_meas < 64) exp_data[n_meas] = link.meas_data;
                        n_meas++;
                        ack_wait = -1;
                    end else ack_wait--;
                end

                if (abort_now) begin
                    abort = 1'b1;
                    aborted = 1;
                    #1;
                    chk_eq("abort_req_drop", 32'(link.meas_req), 0);
                    chk_eq("abort_valid_drop", 32'(link.res_valid), 0);
                end

                if (c > 3000) begin
                    chk_eq("timeout", c, 0);
                    timed_out = 1;
                    fin = 1;
                end else begin
                    @(negedge clk);
                    c++;
                end
            end
        end

        link.meas_ack = 1'b0;
        abort = 1'b0;
        if (!timed_out) begin
            @(negedge clk);
            chk_eq("done_pulse_end", 32'(done), 0);
            chk_eq("idle_busy", 32'(busy), 0);
        end
        $display("sweep %0d start=0x%0h step=0x%0h npts=%0d settle=%0d results=%0d/%0d abort=%0d err_ovf=%0b",
                 sweep_no, s_start, s_step, s_npts, s_settle, n_got, n_exp, abort_sel, err_ovf);
    endtask

    initial begin
        int wait_cnt;
        link.meas_ack  = 1'b0;
        link.meas_data = '0;
        link.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        run_sweep(12'h100, 12'h10, 4, 3, 2, 0, 0);
        run_sweep(12'h000, 12'h05, 0, 2, 0, 0, 0);
        run_sweep(12'h040, 12'h08, 4, 1, 1, 2, 0);
        run_sweep(12'hFF0, 12'h20, 3, 0, 1, 0, 0);
        run_sweep(12'h010, 12'h01, 5, 3, 0, 0, 1);
        run_sweep(12'h010, 12'h01, 5, 0, 0, 0, 2);
        run_sweep(12'h300, 12'h03, 2, 2, -1, 1, 0);

        for (int i = 0; i < 25; i++) begin
            run_sweep($urandom_range(0, CODE_MAX),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12'h300) : $urandom_range(0, 15),
                      $urandom_range(0, 6), $urandom_range(0, 4), -1, 1, 0);
        end

        // Asynchronous reset while a measurement is outstanding.
        sweep_no++;
        @(negedge clk);
        cfg_start = 12'h200; cfg_step = 12'h001; cfg_npts = 3; cfg_settle = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (!link.meas_req && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk_eq("reset_test_req_seen", 32'(link.meas_req), 1);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("async_reset");
        $display("sweep %0d async reset asserted during MEAS", sweep_no);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(12'h123, 12'h011, 3, 2, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
